// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI request arbiter and its helpers.
package spi_arb_pkg;

    localparam int              SPI_W        = 16;
    localparam logic [SPI_W-1:0] RESP_TIMEOUT = 16'hDEAD;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        ACK
    } arb_state_t;

endpackage

// File: rtl/spi_req_arb_rr_pick.sv
// rr_pick: combinational round-robin picker; first set req bit at or above rr_ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               valid,
    output logic [ID_W-1:0]    grant
);

    logic [NUM_REQ-1:0] w_rot;
    logic [ID_W-1:0]    w_off;
    logic [ID_W:0]      w_sum;

    // Rotate so rr_ptr lands at bit 0; the lowest set bit is then the winner's offset.
    assign w_rot = NUM_REQ'({req, req} >> rr_ptr);

    always_comb begin
        valid = |w_rot;
        w_off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = ID_W'(i);
        end
        w_sum = {1'b0, rr_ptr} + {1'b0, w_off};
        grant = (w_sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(w_sum - (ID_W+1)'(NUM_REQ))
                                               : ID_W'(w_sum);
    end

endmodule

// File: rtl/spi_req_arb.sv
// Round-robin arbiter sharing one SPI monarch among NUM_REQ requesters.
// Optional WAIT timeout with error response is enabled by defining SPI_TIMEOUT_EN.
module spi_req_arb
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = $clog2(NUM_REQ),
    parameter int TO_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [SPI_W*NUM_REQ-1:0] cmd_in,
    output logic [NUM_REQ-1:0]       ack,
    output logic [SPI_W-1:0]         resp_out,
    output logic                     err,
    output logic                     busy,
    output logic [ID_W-1:0]          grant_id,
    output logic                     spi_snd,
    output logic [SPI_W-1:0]         spi_cmd,
    input  logic                     spi_done,
    input  logic [SPI_W-1:0]         spi_resp
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TO_CYCLES < 2) begin : g_bad_param
        $error("spi_req_arb: unsupported NUM_REQ or TO_CYCLES");
    end

    arb_state_t       r_state, w_state_nxt;
    logic [ID_W-1:0]  r_grant_id, r_rr_ptr, w_pick_id;
    logic             w_pick_vld;
    logic [SPI_W-1:0] r_spi_cmd, r_resp, w_pick_cmd;
    logic             w_timeout;

    rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr_pick (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .valid  (w_pick_vld),
        .grant  (w_pick_id)
    );

    always_comb begin
        w_pick_cmd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick_id == ID_W'(i)) w_pick_cmd = cmd_in[i*SPI_W +: SPI_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_pick_vld) w_state_nxt = SEND;
            SEND:    w_state_nxt = WAIT;
            WAIT:    if (spi_done || w_timeout) w_state_nxt = ACK;
            ACK:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_spi_cmd  <= '0;
            r_resp     <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_pick_vld) begin
                    r_grant_id <= w_pick_id;
                    r_spi_cmd  <= w_pick_cmd;
                end
                WAIT: begin
                    // A done arriving on the timeout cycle still wins.
                    if (spi_done)       r_resp <= spi_resp;
                    else if (w_timeout) r_resp <= RESP_TIMEOUT;
                end
                ACK: r_rr_ptr <= (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0
                                                                     : r_grant_id + ID_W'(1);
                default: ;
            endcase
        end
    end

`ifdef SPI_TIMEOUT_EN
    logic [15:0] r_wait_cnt;
    logic        r_err;

    assign w_timeout = (r_wait_cnt == 16'(TO_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (r_state == SEND)      r_wait_cnt <= '0;
            else if (r_state == WAIT) r_wait_cnt <= r_wait_cnt + 16'd1;
            if (r_state == WAIT) begin
                if (spi_done)       r_err <= 1'b0;
                else if (w_timeout) r_err <= 1'b1;
            end
        end
    end

    assign err = (r_state == ACK) && r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    assign busy     = (r_state != IDLE);
    assign spi_snd  = (r_state == SEND);
    assign ack      = (r_state == ACK) ? (NUM_REQ'(1) << r_grant_id) : '0;
    assign grant_id = r_grant_id;
    assign spi_cmd  = r_spi_cmd;
    assign resp_out = r_resp;

endmodule

// File: tb/tb_spi_req_arb.sv
// Directed bench for spi_req_arb: expected grants queued as requests are posted, checked as the DUT serves them.
module tb_spi_req_arb;

    localparam int NUM_REQ   = 4;
    localparam int ID_W      = 2;
    localparam int TO_CYCLES = 64;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NUM_REQ-1:0]  req;
    logic [16*NUM_REQ-1:0] cmd_in;
    logic [NUM_REQ-1:0]  ack;
    logic [15:0]         resp_out;
    logic                err;
    logic                busy;
    logic [ID_W-1:0]     grant_id;
    logic                spi_snd;
    logic [15:0]         spi_cmd;
    logic                spi_done;
    logic [15:0]         spi_resp;

    spi_req_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TO_CYCLES(TO_CYCLES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .cmd_in   (cmd_in),
        .ack      (ack),
        .resp_out (resp_out),
        .err      (err),
        .busy     (busy),
        .grant_id (grant_id),
        .spi_snd  (spi_snd),
        .spi_cmd  (spi_cmd),
        .spi_done (spi_done),
        .spi_resp (spi_resp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] cmd;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          snd_cnt = 0;
    int          ack_cnt = 0;
    int          last_lat = 0;
    logic [15:0] last_resp = 16'h0;
    logic [15:0] cmd_tab [4];

    always @(posedge clk) begin
        if (spi_snd === 1'b1) snd_cnt <= snd_cnt + 1;
        if (|ack)             ack_cnt <= ack_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_grant(input int id);
        sb.push_back({2'(id), cmd_tab[id]});
    endtask

    task automatic next_exp(output exp_t e);
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) e = sb.pop_front();
        else               e = '0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ack"},      ack,      0);
        chk({tag, "_resp"},     resp_out, 0);
        chk({tag, "_err"},      err,      0);
        chk({tag, "_busy"},     busy,     0);
        chk({tag, "_grant"},    grant_id, 0);
        chk({tag, "_snd"},      spi_snd,  0);
        chk({tag, "_spi_cmd"},  spi_cmd,  0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        spi_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Returns on the first WAIT-state negedge.
    task automatic wait_snd(input exp_t e);
        int n;
        n = 0;
        while (spi_snd !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        last_lat = n;
        chk("snd_seen",  spi_snd,  1);
        chk("grant_id",  grant_id, e.id);
        chk("spi_cmd",   spi_cmd,  e.cmd);
        chk("busy_send", busy,     1);
        @(negedge clk);
        chk("snd_one_cycle", spi_snd, 0);
    endtask

    task automatic finish_txn(input exp_t e, input int dly, input logic [15:0] resp, input bit drop);
        repeat (dly) @(negedge clk);
        chk("no_ack_in_wait", ack, 0);
        spi_done = 1'b1;
        spi_resp = resp;
        @(negedge clk);
        spi_done = 1'b0;
        spi_resp = 16'h0;
        chk("ack_onehot", ack,      32'(1) << e.id);
        chk("resp_out",   resp_out, resp);
        chk("err_normal", err,      0);
        last_resp = resp;
        if (drop) req[e.id] = 1'b0;
        @(negedge clk);
        chk("ack_one_cycle", ack,      0);
        chk("busy_idle",     busy,     0);
        chk("resp_hold",     resp_out, resp);
    endtask

    initial begin
        exp_t e;
        int   s0, a0, k;

        cmd_tab[0] = 16'h8F00;
        cmd_tab[1] = 16'h1111;
        cmd_tab[2] = 16'h2222;
        cmd_tab[3] = 16'h3333;
        cmd_in   = {cmd_tab[3], cmd_tab[2], cmd_tab[1], cmd_tab[0]};
        req      = '0;
        spi_done = 1'b0;
        spi_resp = 16'h0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single request, slow monarch
        req = 4'b0001;
        expect_grant(0);
        next_exp(e);
        wait_snd(e);
        chk("t1_latency", last_lat, 1);
        finish_txn(e, 40, 16'h00A5, 1'b1);

        // 2: all requesting, rotation from pointer 0
        do_reset();
        s0 = snd_cnt;
        a0 = ack_cnt;
        req = 4'b1111;
        expect_grant(0); expect_grant(1); expect_grant(2); expect_grant(3); expect_grant(0);
        for (int i = 0; i < 5; i++) begin
            next_exp(e);
            wait_snd(e);
            if (i > 0) chk("t2_handoff", last_lat, 1);
            finish_txn(e, 2 + i, 16'h1000 + 16'(i), 1'b0);
        end
        req = '0;
        chk("t2_snd_count", snd_cnt - s0, 5);
        chk("t2_ack_count", ack_cnt - a0, 5);

        // 3: sparse requests, late arrival of 0 and 1
        do_reset();
        req = 4'b1010;
        expect_grant(1); expect_grant(3); expect_grant(0); expect_grant(1);
        next_exp(e);
        wait_snd(e);
        finish_txn(e, 3, 16'h3A01, 1'b1);
        req = req | 4'b0011;
        for (int i = 0; i < 3; i++) begin
            next_exp(e);
            wait_snd(e);
            finish_txn(e, 1 + i, 16'h3B00 + 16'(i), 1'b1);
        end

        // 4: spi_done outside WAIT is ignored
        spi_done = 1'b1;
        spi_resp = 16'hFFFF;
        @(negedge clk);
        spi_done = 1'b0;
        chk("t4_idle_ack",  ack,      0);
        chk("t4_idle_resp", resp_out, last_resp);
        chk("t4_idle_busy", busy,     0);
        req[2] = 1'b1;
        expect_grant(2);
        next_exp(e);
        @(negedge clk);
        chk("t4_send_snd",   spi_snd,  1);
        chk("t4_send_grant", grant_id, e.id);
        spi_done = 1'b1;
        @(negedge clk);
        spi_done = 1'b0;
        spi_resp = 16'h0;
        chk("t4_send_ack",  ack,      0);
        chk("t4_send_resp", resp_out, last_resp);
        chk("t4_wait_busy", busy,     1);
        chk("t4_wait_snd",  spi_snd,  0);
        finish_txn(e, 3, 16'h0C0C, 1'b1);

        // 5: reset mid-WAIT, then a fresh grant
        req[1] = 1'b1;
        expect_grant(1);
        next_exp(e);
        wait_snd(e);
        repeat (5) @(negedge clk);
        a0 = ack_cnt;
        rst_n = 1'b0;
        req = '0;
        #1;
        check_reset("t5_abort");
        repeat (2) @(negedge clk);
        chk("t5_no_ack", ack_cnt - a0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        req[2] = 1'b1;
        expect_grant(2);
        next_exp(e);
        wait_snd(e);
        chk("t5_latency", last_lat, 1);
        finish_txn(e, 4, 16'h5A5A, 1'b1);

`ifdef SPI_TIMEOUT_EN
        // 6: timeout with no done, then the next requester normally
        req = 4'b1001;
        expect_grant(3); expect_grant(0);
        next_exp(e);
        wait_snd(e);
        k = 0;
        while (ack === 4'b0000 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("t6_to_cycles", k,        TO_CYCLES);
        chk("t6_to_ack",    ack,      4'b1000);
        chk("t6_to_err",    err,      1);
        chk("t6_to_resp",   resp_out, 16'hDEAD);
        req[3] = 1'b0;
        @(negedge clk);
        chk("t6_err_clear", err, 0);
        next_exp(e);
        wait_snd(e);
        finish_txn(e, 5, 16'h0BEE, 1'b1);
`else
        // 6: without the timeout, WAIT holds indefinitely
        req = 4'b0001;
        expect_grant(0);
        next_exp(e);
        wait_snd(e);
        repeat (100) @(negedge clk);
        chk("t6_still_wait", busy, 1);
        chk("t6_no_ack",     ack,  0);
        chk("t6_no_err",     err,  0);
        finish_txn(e, 0, 16'h0BEE, 1'b1);
`endif

        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
